// File: rtl/store_narrow_rmw.sv
// Narrowing store unit: writes byte/halfword/word slices of a register value
// into word-organised memory, using read-modify-write for sub-word stores and
// flagging values that do not survive narrowing plus sign extension.
module store_narrow_rmw #(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rd_valid,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err,
  output logic              trunc_ovf
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_FIN,
    S_ERR
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        addr_q;
  logic [15:0]        data_q;
  logic [1:0]         size_q;
  logic               ovf_q;
  logic [31:0]        wdata_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept_c;
  logic               misalign_c;
  logic               ovf_c;
  logic [31:0]        merge_c;

  logic               req_ready_c;
  logic               mem_rd_en_c;
  logic               mem_wr_en_c;
  logic               done_c;
  logic               err_c;
  logic               trunc_ovf_c;
  logic [ADDR_W-1:0]  mem_addr_c;
  logic [31:0]        mem_wdata_c;

  // Request qualification: acceptance, alignment and narrowing-loss checks
  always_comb begin
    accept_c   = req_valid && (state == S_IDLE);
    misalign_c = (req_size == 2'b11) ||
                 ((req_size == SZ_HALF) && req_addr[0]) ||
                 ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    ovf_c      = 1'b0;
    if (req_size == SZ_BYTE) begin
      ovf_c = (req_data[31:8] != {24{req_data[7]}});
    end else if (req_size == SZ_HALF) begin
      ovf_c = (req_data[31:16] != {16{req_data[15]}});
    end
  end

  // Lane merge of the captured store data into the returned memory word
  always_comb begin
    merge_c = mem_rdata;
    if (size_q == SZ_BYTE) begin
      merge_c[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    end else if (addr_q[1]) begin
      merge_c[31:16] = data_q;
    end else begin
      merge_c[15:0] = data_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; read data arriving on the timeout cycle still wins
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept_c) begin
          if (misalign_c) begin
            state_nxt = S_ERR;
          end else if (req_size == SZ_WORD) begin
            state_nxt = S_WRITE;
          end else begin
            state_nxt = S_READ;
          end
        end
      end
      S_READ:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_rd_valid) begin
          state_nxt = S_WRITE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_nxt = S_ERR;
        end
      end
      S_WRITE: state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode; ready tracks the state being entered so it never lags
  always_comb begin
    req_ready_c = (state_nxt == S_IDLE);
    mem_rd_en_c = (state == S_READ);
    mem_wr_en_c = (state == S_WRITE);
    done_c      = (state == S_FIN);
    err_c       = (state == S_ERR);
    trunc_ovf_c = (state == S_FIN) && ovf_q;
    mem_addr_c  = mem_addr;
    mem_wdata_c = mem_wdata;
    if ((state == S_READ) || (state == S_WRITE)) begin
      mem_addr_c = addr_q[ADDR_W+1:2];
    end
    if (state == S_WRITE) begin
      mem_wdata_c = wdata_q;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      trunc_ovf <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      req_ready <= req_ready_c;
      mem_rd_en <= mem_rd_en_c;
      mem_wr_en <= mem_wr_en_c;
      done      <= done_c;
      err       <= err_c;
      trunc_ovf <= trunc_ovf_c;
      mem_addr  <= mem_addr_c;
      mem_wdata <= mem_wdata_c;
    end
  end

  // Request capture, merged write word and wait-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      ovf_q   <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept_c) begin
        addr_q  <= req_addr;
        data_q  <= req_data[15:0];
        size_q  <= req_size;
        ovf_q   <= ovf_c;
        wdata_q <= req_data;
      end
      if (state == S_READ) begin
        cnt_q <= '0;
      end else if (state == S_WAIT) begin
        if (mem_rd_valid) begin
          wdata_q <= merge_c;
        end else if (cnt_q != CNT_W'(TIMEOUT)) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule
